mips_multicycle_control: RTL

Multi-cycle MIPS control unit: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback cycles. It drives the datapath mux selects and write enables, and produces the 4-bit `ALU_control` consumed by the ALU. It takes the ALU's `zero` flag back to resolve branches, closing the control side of the ALU interface.

---
 rtl/mips_multicycle_control_pkg.sv | 104 ++++++++++
 rtl/mips_multicycle_control_alu_funct_decode.sv | 38 +++
 rtl/mips_multicycle_control.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_control_pkg.sv
// -----------------------------------------------------------------------------
// mips_multicycle_control_pkg
// Shared encodings for the multi-cycle MIPS control unit: word width, ALU
// operation codes, opcode and funct values, FSM state encoding and the
// control-word bundle that the FSM registers.
//
// Optional feature macro: MC_IMM_EN adds the addi/slti states (S_IMM_EX and
// S_IMM_WB) and makes opcodes 0x08/0x0A legal.
// -----------------------------------------------------------------------------
package mips_multicycle_control_pkg;

  localparam int WORD = 32;

  // ALU operation codes understood by the datapath ALU
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // Instruction opcodes (bits [31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (bits [5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ      = 4'd8,
`ifdef MC_IMM_EN
    S_JUMP     = 4'd9,
    S_IMM_EX   = 4'd10,
    S_IMM_WB   = 4'd11
`else
    S_JUMP     = 4'd9
`endif
  } state_t;

  // Control word held in registers alongside the state
  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [3:0] alu_control;
    logic       instr_done;
  } ctrl_t;

  // Everything inactive; the ALU idles on ADD
  localparam ctrl_t CTRL_IDLE = '{
    pc_write: 1'b0, iord: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
    ir_write: 1'b0, mem_to_reg: 1'b0, reg_dst: 1'b0, reg_write: 1'b0,
    alu_src_a: 1'b0, alu_src_b: 2'b00, pc_source: 2'b00,
    alu_control: ALU_ADD, instr_done: 1'b0
  };

  // FETCH: read at PC, load IR, PC <= PC + 4
  localparam ctrl_t CTRL_FETCH = '{
    pc_write: 1'b1, iord: 1'b0, mem_read: 1'b1, mem_write: 1'b0,
    ir_write: 1'b1, mem_to_reg: 1'b0, reg_dst: 1'b0, reg_write: 1'b0,
    alu_src_a: 1'b0, alu_src_b: 2'b01, pc_source: 2'b00,
    alu_control: ALU_ADD, instr_done: 1'b0
  };

  // True for every opcode the control unit knows how to sequence
  function automatic logic opcode_supported(input logic [5:0] op);
    logic ok;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
`ifdef MC_IMM_EN
      OP_ADDI, OP_SLTI:                     ok = 1'b1;
`endif
      default:                              ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mips_multicycle_control_alu_funct_decode.sv
// -----------------------------------------------------------------------------
// alu_funct_decode
// Combinational translation of an R-type funct field into the ALU operation
// code. Unknown funct values fall back to ADD with valid low so the caller can
// suppress the register write.
//
// Ports:
//   funct       in  6  instruction bits [5:0]
//   alu_control out 4  ALU operation code
//   valid       out 1  funct is one of the supported R-type operations
// -----------------------------------------------------------------------------
module alu_funct_decode
  import mips_multicycle_control_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_control,
  output logic       valid
);

  // funct lookup with a safe ADD fallback
  always_comb begin
    alu_control = ALU_ADD;
    valid       = 1'b1;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_NOR:  alu_control = ALU_NOR;
      FN_SLT:  alu_control = ALU_SLT;
      default: begin
        alu_control = ALU_ADD;
        valid       = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// -----------------------------------------------------------------------------
// mips_multicycle_control
// Moore FSM that steps each MIPS instruction through fetch, decode, execute,
// memory and writeback, driving the datapath selects/enables and ALU_control.
// Control outputs are registered: the register is loaded with the control word
// of the state being entered, so the outputs always match the current state.
// Two outputs are combinational by nature: PCWrite in BEQ (qualified by the
// ALU zero flag in the same cycle) and illegal_op in DECODE (opcode check).
// While rst_n is low the outputs show FETCH values with all write enables and
// pulses forced low, so an abandoned instruction never writes anything.
//
// Optional feature macro: MC_IMM_EN enables addi/slti (IMM_EX, IMM_WB).
//
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   opcode, funct         instruction fields from the instruction register
//   zero                  ALU equality flag, used only in BEQ
//   PCWrite..PCSource     datapath enables and mux selects
//   ALU_control           ALU operation code
//   instr_done            pulse in the last cycle of each instruction
//   illegal_op            pulse in DECODE for an unsupported opcode
// -----------------------------------------------------------------------------
module mips_multicycle_control
  import mips_multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] ALU_control,
  output logic       instr_done,
  output logic       illegal_op
);

  state_t     state_r;
  state_t     next_state_s;
  ctrl_t      ctrl_r;
  ctrl_t      ctrl_next_s;
  ctrl_t      ctrl_s;
  logic [3:0] funct_alu_s;
  logic       funct_ok_s;
  logic       beq_take_s;

  alu_funct_decode u_funct_decode (
    .funct       (funct),
    .alu_control (funct_alu_s),
    .valid       (funct_ok_s)
  );

  // Next-state selection
  always_comb begin
    next_state_s = S_FETCH;
    case (state_r)
      S_FETCH:  next_state_s = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state_s = S_MEMADR;
          OP_RTYPE:     next_state_s = S_RTYPE_EX;
          OP_BEQ:       next_state_s = S_BEQ;
          OP_J:         next_state_s = S_JUMP;
`ifdef MC_IMM_EN
          OP_ADDI, OP_SLTI: next_state_s = S_IMM_EX;
`endif
          default:      next_state_s = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW) begin
          next_state_s = S_MEMRD;
        end else if (opcode == OP_SW) begin
          next_state_s = S_MEMWR;
        end else begin
          // IR cannot change mid-instruction; recover cleanly if it does
          next_state_s = S_FETCH;
        end
      end
      S_MEMRD:    next_state_s = S_MEMWB;
      S_RTYPE_EX: next_state_s = S_RTYPE_WB;
`ifdef MC_IMM_EN
      S_IMM_EX:   next_state_s = S_IMM_WB;
`endif
      default:    next_state_s = S_FETCH;
    endcase
  end

  // Control word for the state about to be entered; funct/opcode are stable
  // in the IR from DECODE onwards, so looking one state ahead is safe
  always_comb begin
    ctrl_next_s = CTRL_IDLE;
    case (next_state_s)
      S_FETCH:  ctrl_next_s = CTRL_FETCH;
      S_DECODE: ctrl_next_s.alu_src_b = 2'b11;
      S_MEMADR: begin
        ctrl_next_s.alu_src_a = 1'b1;
        ctrl_next_s.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        ctrl_next_s.mem_read = 1'b1;
        ctrl_next_s.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl_next_s.reg_write  = 1'b1;
        ctrl_next_s.mem_to_reg = 1'b1;
        ctrl_next_s.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl_next_s.mem_write  = 1'b1;
        ctrl_next_s.iord       = 1'b1;
        ctrl_next_s.instr_done = 1'b1;
      end
      S_RTYPE_EX: begin
        ctrl_next_s.alu_src_a   = 1'b1;
        ctrl_next_s.alu_control = funct_alu_s;
      end
      S_RTYPE_WB: begin
        // unknown funct completes as a no-op rather than trapping
        ctrl_next_s.reg_write  = funct_ok_s;
        ctrl_next_s.reg_dst    = 1'b1;
        ctrl_next_s.instr_done = 1'b1;
      end
      S_BEQ: begin
        // pc_write stays 0 here; the taken branch is qualified by zero below
        ctrl_next_s.alu_src_a   = 1'b1;
        ctrl_next_s.alu_control = ALU_SUB;
        ctrl_next_s.pc_source   = 2'b01;
        ctrl_next_s.instr_done  = 1'b1;
      end
      S_JUMP: begin
        ctrl_next_s.pc_source  = 2'b10;
        ctrl_next_s.pc_write   = 1'b1;
        ctrl_next_s.instr_done = 1'b1;
      end
`ifdef MC_IMM_EN
      S_IMM_EX: begin
        ctrl_next_s.alu_src_a   = 1'b1;
        ctrl_next_s.alu_src_b   = 2'b10;
        ctrl_next_s.alu_control = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_IMM_WB: begin
        ctrl_next_s.reg_write  = 1'b1;
        ctrl_next_s.instr_done = 1'b1;
      end
`endif
      default: ctrl_next_s = CTRL_IDLE;
    endcase
  end

  // State and registered control word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
      ctrl_r  <= CTRL_FETCH;
    end else begin
      state_r <= next_state_s;
      ctrl_r  <= ctrl_next_s;
    end
  end

  // Reset override: FETCH selects with every write enable and pulse held low
  always_comb begin
    if (rst_n) begin
      ctrl_s = ctrl_r;
    end else begin
      ctrl_s            = CTRL_FETCH;
      ctrl_s.pc_write   = 1'b0;
      ctrl_s.ir_write   = 1'b0;
      ctrl_s.mem_write  = 1'b0;
      ctrl_s.reg_write  = 1'b0;
      ctrl_s.instr_done = 1'b0;
    end
  end

  // Branch resolution in the same cycle as the SUB compare
  always_comb begin
    beq_take_s = rst_n && (state_r == S_BEQ) && zero;
  end

  // Output mapping
  always_comb begin
    PCWrite     = ctrl_s.pc_write | beq_take_s;
    IorD        = ctrl_s.iord;
    MemRead     = ctrl_s.mem_read;
    MemWrite    = ctrl_s.mem_write;
    IRWrite     = ctrl_s.ir_write;
    MemtoReg    = ctrl_s.mem_to_reg;
    RegDst      = ctrl_s.reg_dst;
    RegWrite    = ctrl_s.reg_write;
    ALUSrcA     = ctrl_s.alu_src_a;
    ALUSrcB     = ctrl_s.alu_src_b;
    PCSource    = ctrl_s.pc_source;
    ALU_control = ctrl_s.alu_control;
    instr_done  = ctrl_s.instr_done;
    illegal_op  = rst_n && (state_r == S_DECODE) && !opcode_supported(opcode);
  end

endmodule
